// File: rtl/mem_pattern_tester.sv
// mem_pattern_tester: multi-pass write/read-back pattern checker for the sdram user port.
// Define MEM_TEST_LFSR_EN to enable the LFSR pattern on mode 2'b10 (otherwise it aliases mode 2'b00).
module mem_pattern_tester #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 2**23-1,
    parameter int PASSES     = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    input  logic              busy,
    output logic              in_valid,
    input  logic              out_valid,
    output logic              done,
    output logic              fail,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [7:0]        leds
);
    localparam logic [ADDR_W-1:0] SA = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] EA = ADDR_W'(END_ADDR);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE_ST} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        pass_idx;
    logic [1:0]        mode_r;
    logic [TW-1:0]     tmo;
    logic              adv, err, last, pass_last, tmo_hit, accept;
    logic [DATA_W-1:0] pinv, pat;

    assign last      = addr_r == EA;
    assign pass_last = pass_idx + 8'd1 == 8'(PASSES);
    assign tmo_hit   = tmo == TW'(TIMEOUT);
    assign accept    = (state == IDLE || state == DONE_ST) && start;
    assign pinv      = {DATA_W{pass_idx[0]}};
    assign addr      = addr_r;
    assign rw        = state == WR_REQ;
    assign data_in   = rw ? pat : '0;
    assign leds      = {done, fail, pass_idx[5:0]};

`ifdef MEM_TEST_LFSR_EN
    localparam logic [31:0] POLY = 32'h8020_0003;
    localparam logic [31:0] SEED = 32'hACE1_0000;
    logic [31:0] lfsr;
    always_comb
        pat = mode_r == 2'b11 ? ~pinv :
              mode_r == 2'b01 ? (DATA_W'(1) << (addr_r % ADDR_W'(DATA_W))) ^ pinv :
              mode_r == 2'b10 ? lfsr[DATA_W-1:0] : DATA_W'(addr_r) ^ pinv;
    // Reseed at each phase boundary so the read phase regenerates the write sequence.
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            lfsr <= '0;
        else if (accept)
            lfsr <= SEED;
        else if (adv)
            lfsr <= (state == WR_WAIT && last) ? SEED + {24'd0, pass_idx} :
                    (state == RD_WAIT && last) ? SEED + {24'd0, pass_idx + 8'd1} :
                    (lfsr >> 1) ^ (lfsr[0] ? POLY : 32'd0);
`else
    always_comb
        pat = mode_r == 2'b11 ? ~pinv :
              mode_r == 2'b01 ? (DATA_W'(1) << (addr_r % ADDR_W'(DATA_W))) ^ pinv :
              DATA_W'(addr_r) ^ pinv;
`endif

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n  = state;
        in_valid = 1'b0;
        adv      = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE, DONE_ST: state_n = start ? WR_REQ : state;
            WR_REQ: begin
                in_valid = !busy;
                state_n  = busy ? WR_REQ : WR_WAIT;
            end
            WR_WAIT: begin
                adv     = !busy;
                state_n = busy ? WR_WAIT : last ? RD_REQ : WR_REQ;
            end
            RD_REQ: begin
                in_valid = !busy;
                state_n  = busy ? RD_REQ : RD_WAIT;
            end
            RD_WAIT: begin
                adv     = out_valid || tmo_hit;
                err     = adv && (!out_valid || data_out != pat);
                state_n = !adv ? RD_WAIT : !last ? RD_REQ : pass_last ? DONE_ST : WR_REQ;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            addr_r         <= '0;
            pass_idx       <= '0;
            mode_r         <= '0;
            tmo            <= '0;
            done           <= 1'b0;
            fail           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            tmo <= state == RD_WAIT ? tmo + 1'b1 : '0;
            if (accept) begin
                addr_r         <= SA;
                pass_idx       <= '0;
                mode_r         <= mode;
                done           <= 1'b0;
                fail           <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end
            if (adv) begin
                addr_r <= last ? SA : addr_r + 1'b1;
                if (state == RD_WAIT && last) begin
                    pass_idx <= pass_idx + 8'd1;
                    done     <= pass_last;
                end
            end
            if (err) begin
                if (~&err_count)
                    err_count <= err_count + 16'd1;
                fail <= 1'b1;
                if (!fail)
                    first_err_addr <= addr_r;
            end
        end
endmodule
